// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: bundles the VGA timing, external write, clear and RAM
//   signals shared between the frame-buffer arbiter and its clients.
// Ports: slave = arbiter view (drives WrAck, ClearBusy, Mem*, PixData);
//   master = environment view (VGA driver, writer, clear requester, RAM).
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 15
);
  logic [10:0]       CurrentX;
  logic [10:0]       CurrentY;
  logic              HBlank;
  logic              VBlank;
  logic              WrReq;
  logic [ADDR_W-1:0] WrAddr;
  logic [11:0]       WrData;
  logic              WrAck;
  logic              ClearReq;
  logic [11:0]       ClearColor;
  logic              ClearBusy;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemWE;
  logic [11:0]       MemWData;
  logic [11:0]       MemRData;
  logic [11:0]       PixData;

  modport slave (
    input  CurrentX, CurrentY, HBlank, VBlank,
    input  WrReq, WrAddr, WrData, ClearReq, ClearColor, MemRData,
    output WrAck, ClearBusy, MemAddr, MemWE, MemWData, PixData
  );

  modport master (
    output CurrentX, CurrentY, HBlank, VBlank,
    output WrReq, WrAddr, WrData, ClearReq, ClearColor, MemRData,
    input  WrAck, ClearBusy, MemAddr, MemWE, MemWData, PixData
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port pixel RAM between display reads, a
//   full-buffer clear sequencer and an external req/ack write port.
// Latency: read address on MemAddr 1 cycle after an X change, PixData 3 cycles after.
// Backpressure: reads never stall; clear writes use free cycles; external writes
//   wait (WrAck low) until no read, no clear and no ack in the previous cycle.
// Ports: CLK_100MHz, Reset (async, active high) plain; everything else via bus.
module vga_fb_arbiter #(
  parameter int FB_W   = 160,
  parameter int FB_H   = 120,
  parameter int ADDR_W = 15
) (
  input  logic            CLK_100MHz,
  input  logic            Reset,
  vga_fb_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);
  localparam logic [15:0]       FB_W_BITS = 16'(FB_W);

  typedef enum logic {IDLE, CLEARING} clr_state_e;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [11:0]       color_q, color_d;
  logic [10:0]       x_q, x_d;
  logic              v1_q, v1_d;
  logic              v2_q, v2_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [11:0]       mem_wdata_q, mem_wdata_d;
  logic              wr_ack_q, wr_ack_d;
  logic [11:0]       pix_q, pix_d;

  logic              visible;
  logic              read_evt;
  logic              clr_gnt;
  logic              wr_gnt;
  logic [25:0]       rd_prod;
  logic [ADDR_W-1:0] rd_addr;

  always_comb begin
    visible  = !bus.HBlank && !bus.VBlank &&
               (bus.CurrentX < 11'd640) && (bus.CurrentY < 11'd480);
    read_evt = visible && (bus.CurrentX != x_q);
  end

  // (Y>>2)*FB_W as a sum of shifted copies of Y>>2, one per set bit of FB_W
  // (for 160 this is (Yq<<7)+(Yq<<5)), plus X>>2.
  always_comb begin
    rd_prod = 26'(bus.CurrentX[10:2]);
    for (int i = 0; i < 16; i++) begin
      if (FB_W_BITS[i]) rd_prod = rd_prod + (26'(bus.CurrentY[10:2]) << i);
    end
    rd_addr = rd_prod[ADDR_W-1:0];
  end

  always_comb begin
    clr_gnt = (state_q == CLEARING) && !read_evt;
    // A ClearReq accepted this cycle already outranks a waiting write.
    wr_gnt  = bus.WrReq && (state_q == IDLE) && !bus.ClearReq && !wr_ack_q && !read_evt;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    color_d     = color_q;
    x_d         = bus.CurrentX;
    v1_d        = read_evt;
    v2_d        = v1_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    wr_ack_d    = 1'b0;
    pix_d       = pix_q;

    case (state_q)
      IDLE: begin
        if (bus.ClearReq) begin
          state_d = CLEARING;
          cnt_d   = '0;
          color_d = bus.ClearColor;
        end
      end
      CLEARING: begin
        if (clr_gnt) begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (cnt_q == LAST_ADDR) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (read_evt) begin
      mem_addr_d = rd_addr;
    end else if (clr_gnt) begin
      mem_addr_d  = cnt_q;
      mem_we_d    = 1'b1;
      mem_wdata_d = color_q;
    end else if (wr_gnt) begin
      mem_addr_d  = bus.WrAddr;
      mem_we_d    = 1'b1;
      mem_wdata_d = bus.WrData;
      wr_ack_d    = 1'b1;
    end

    // A read landing in stage 2 wins over blanking so a pixel fetched just
    // before blank starts is not lost; blanking reloads black afterwards.
    if (v2_q) begin
      pix_d = bus.MemRData;
    end else if (bus.HBlank || bus.VBlank) begin
      pix_d = '0;
    end
  end

  always_ff @(posedge CLK_100MHz or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      color_q     <= '0;
      x_q         <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      wr_ack_q    <= 1'b0;
      pix_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      color_q     <= color_d;
      x_q         <= x_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      wr_ack_q    <= wr_ack_d;
      pix_q       <= pix_d;
    end
  end

  assign bus.WrAck     = wr_ack_q;
  assign bus.ClearBusy = (state_q == CLEARING);
  assign bus.MemAddr   = mem_addr_q;
  assign bus.MemWE     = mem_we_q;
  assign bus.MemWData  = mem_wdata_q;
  assign bus.PixData   = pix_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;
  localparam int FB_W   = 160;
  localparam int FB_H   = 120;
  localparam int ADDR_W = 15;
  localparam int NPIX   = FB_W * FB_H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_fb_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  vga_fb_arbiter #(.FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W)) dut (
    .CLK_100MHz(clk),
    .Reset     (rst),
    .bus       (bus)
  );

  // Synchronous single-port RAM model with a backdoor for preloading.
  logic [11:0] ram    [NPIX];
  logic [11:0] shadow [NPIX];
  logic        fill_req  = 1'b0;
  logic        poke_we   = 1'b0;
  int          poke_addr = 0;
  logic [11:0] poke_dat  = 12'h000;

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < NPIX; i++) ram[i] <= 12'(i * 37 + 5);
    end else if (poke_we) begin
      ram[poke_addr] <= poke_dat;
    end else if (bus.MemWE && int'(bus.MemAddr) < NPIX) begin
      ram[bus.MemAddr] <= bus.MemWData;
    end
    bus.MemRData <= (int'(bus.MemAddr) < NPIX) ? ram[bus.MemAddr] : 12'h000;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.CurrentX   = 11'd0;
    bus.CurrentY   = 11'd0;
    bus.HBlank     = 1'b0;
    bus.VBlank     = 1'b0;
    bus.WrReq      = 1'b0;
    bus.WrAddr     = '0;
    bus.WrData     = 12'h000;
    bus.ClearReq   = 1'b0;
    bus.ClearColor = 12'h000;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic poke(input int addr, input logic [11:0] dat);
    poke_addr = addr;
    poke_dat  = dat;
    poke_we   = 1'b1;
    tick();
    poke_we   = 1'b0;
  endtask

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic        hb;
    logic        vb;
    logic [14:0] exp_addr;
    logic [11:0] exp_pix;
  } vec_t;

  vec_t vt [10];

  // Random-phase reference model state
  logic [10:0] m_prevx;
  logic [14:0] m_addr;
  logic        m_we, m_ack;
  logic [11:0] m_wdata, m_pix;
  logic        s0v, s1v;
  logic [11:0] s0d, s1d;
  logic        req_on;
  logic [14:0] req_addr;
  logic [11:0] req_dat;
  logic [10:0] rx, ry;
  logic        rhb, rvb, rd;
  int          ra;

  int we_seen, busy_cnt, nclr, bad_clr, ack_cyc, fall_cyc, cyc, found, wcnt, badw;

  initial begin
    // {x, y, hb, vb, MemAddr one cycle later, PixData three cycles later}
    vt[0] = '{11'd8,   11'd8,   1'b0, 1'b0, 15'd322,   12'hABC};
    vt[1] = '{11'd639, 11'd479, 1'b0, 1'b0, 15'd19199, 12'h123};
    vt[2] = '{11'd640, 11'd10,  1'b0, 1'b0, 15'd19199, 12'h123};
    vt[3] = '{11'd12,  11'd480, 1'b0, 1'b0, 15'd19199, 12'h123};
    vt[4] = '{11'd20,  11'd20,  1'b1, 1'b0, 15'd19199, 12'h000};
    vt[5] = '{11'd24,  11'd20,  1'b0, 1'b1, 15'd19199, 12'h000};
    vt[6] = '{11'd0,   11'd0,   1'b0, 1'b0, 15'd0,     12'h5A5};
    vt[7] = '{11'd0,   11'd4,   1'b0, 1'b0, 15'd0,     12'h5A5};
    vt[8] = '{11'd628, 11'd400, 1'b0, 1'b0, 15'd16157, 12'h777};
    vt[9] = '{11'd3,   11'd3,   1'b0, 1'b0, 15'd0,     12'h5A5};

    idle_inputs();
    rst = 1'b1;
    fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
    do_reset();

    // Reset state and quiet bus
    chk("rst_pix", bus.PixData, 0);
    chk("rst_addr", bus.MemAddr, 0);
    chk("rst_we", bus.MemWE, 0);
    chk("rst_wdata", bus.MemWData, 0);
    chk("rst_ack", bus.WrAck, 0);
    chk("rst_busy", bus.ClearBusy, 0);
    we_seen = 0;
    repeat (100) begin
      tick();
      if (bus.MemWE) we_seen++;
    end
    chk("idle_we_count", we_seen, 0);

    poke(322, 12'hABC);
    poke(19199, 12'h123);
    poke(0, 12'h5A5);
    poke(16157, 12'h777);
    poke(1610, 12'h9C3);

    // Table-driven display reads
    for (int r = 0; r < 10; r++) begin
      bus.CurrentX = vt[r].x;
      bus.CurrentY = vt[r].y;
      bus.HBlank   = vt[r].hb;
      bus.VBlank   = vt[r].vb;
      tick();
      chk($sformatf("vec%0d_addr", r), bus.MemAddr, vt[r].exp_addr);
      chk($sformatf("vec%0d_we", r), bus.MemWE, 0);
      tick();
      tick();
      chk($sformatf("vec%0d_pix", r), bus.PixData, vt[r].exp_pix);
      tick();
    end

    // External write in blanking, WrReq held for a second transfer
    bus.HBlank = 1'b1;
    bus.WrReq  = 1'b1;
    bus.WrAddr = 15'd100;
    bus.WrData = 12'h0F0;
    tick();
    chk("wr1_ack", bus.WrAck, 1);
    chk("wr1_we", bus.MemWE, 1);
    chk("wr1_addr", bus.MemAddr, 100);
    chk("wr1_data", bus.MemWData, 12'h0F0);
    bus.WrAddr = 15'd101;
    bus.WrData = 12'h0A5;
    tick();
    chk("wr2_gap_ack", bus.WrAck, 0);
    tick();
    chk("wr2_ack", bus.WrAck, 1);
    chk("wr2_addr", bus.MemAddr, 101);
    bus.WrReq = 1'b0;
    tick();
    tick();
    chk("wr1_ram", ram[100], 12'h0F0);
    chk("wr2_ram", ram[101], 12'h0A5);

    // Read event and write request in the same cycle
    bus.HBlank   = 1'b0;
    bus.CurrentX = 11'd40;
    bus.CurrentY = 11'd40;
    bus.WrReq    = 1'b1;
    bus.WrAddr   = 15'd200;
    bus.WrData   = 12'h321;
    tick();
    chk("coll_rd_addr", bus.MemAddr, 1610);
    chk("coll_rd_we", bus.MemWE, 0);
    chk("coll_rd_ack", bus.WrAck, 0);
    tick();
    chk("coll_wr_ack", bus.WrAck, 1);
    chk("coll_wr_bus", {bus.MemWE, bus.MemAddr, bus.MemWData}, {1'b1, 15'd200, 12'h321});
    bus.WrReq = 1'b0;
    tick();
    chk("coll_pix", bus.PixData, 12'h9C3);

    // Randomized traffic against a cycle-level reference model
    do_reset();
    for (int i = 0; i < NPIX; i++) shadow[i] = ram[i];
    m_prevx = '0; m_addr = '0; m_we = 1'b0; m_ack = 1'b0; m_wdata = '0; m_pix = '0;
    s0v = 1'b0; s1v = 1'b0; s0d = '0; s1d = '0;
    req_on = 1'b0; req_addr = '0; req_dat = '0;
    rx = '0; ry = '0; rhb = 1'b0; rvb = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_bus", {bus.MemAddr, bus.MemWE, bus.WrAck, bus.MemWE ? bus.MemWData : 12'h000},
                     {m_addr, m_we, m_ack, m_we ? m_wdata : 12'h000});
      chk("rnd_pix", bus.PixData, m_pix);

      // New pixel slot every 4 cycles
      if (c % 4 == 0) begin
        if ($urandom_range(0, 3) != 0) rx = 11'($urandom_range(0, 700));
        ry  = 11'($urandom_range(0, 499));
        rhb = ($urandom_range(0, 5) == 0);
        rvb = ($urandom_range(0, 7) == 0);
      end
      // Requester: hold until acked, then drop or start the next transfer
      if (req_on) begin
        if (bus.WrAck) begin
          if ($urandom_range(0, 1) == 1) begin
            req_addr = 15'($urandom_range(0, NPIX - 1));
            req_dat  = 12'($urandom);
          end else begin
            req_on = 1'b0;
          end
        end
      end else if ($urandom_range(0, 3) == 0) begin
        req_on   = 1'b1;
        req_addr = 15'($urandom_range(0, NPIX - 1));
        req_dat  = 12'($urandom);
      end
      bus.CurrentX = rx;
      bus.CurrentY = ry;
      bus.HBlank   = rhb;
      bus.VBlank   = rvb;
      bus.WrReq    = req_on;
      bus.WrAddr   = req_addr;
      bus.WrData   = req_dat;

      // Predict next cycle from the arbitration rules
      rd = (rx != m_prevx) && !rhb && !rvb && (rx < 640) && (ry < 480);
      m_prevx = rx;
      if (rd) begin
        ra     = (int'(ry) / 4) * FB_W + int'(rx) / 4;
        m_addr = 15'(ra);
        m_we   = 1'b0;
        m_ack  = 1'b0;
      end else if (req_on && !m_ack) begin
        m_addr  = req_addr;
        m_we    = 1'b1;
        m_ack   = 1'b1;
        m_wdata = req_dat;
        shadow[req_addr] = req_dat;
      end else begin
        m_we  = 1'b0;
        m_ack = 1'b0;
      end
      if (s1v) m_pix = s1d;
      else if (rhb || rvb) m_pix = 12'h000;
      s1v = s0v;
      s1d = s0d;
      s0v = rd;
      s0d = rd ? shadow[m_addr] : 12'h000;
      tick();
    end
    bus.WrReq = 1'b0;

    // Full clear with a simultaneous write request, all in blanking
    do_reset();
    bus.VBlank     = 1'b1;
    bus.ClearReq   = 1'b1;
    bus.ClearColor = 12'h00F;
    bus.WrReq      = 1'b1;
    bus.WrAddr     = 15'd300;
    bus.WrData     = 12'hBEE;
    tick();
    bus.ClearReq   = 1'b0;
    bus.ClearColor = 12'hFFF;
    chk("clr_busy_rise", bus.ClearBusy, 1);
    busy_cnt = 0; nclr = 0; bad_clr = 0; ack_cyc = -1; fall_cyc = -1; cyc = 1;
    while (cyc < 19400 && ack_cyc < 0) begin
      if (bus.ClearBusy) busy_cnt++;
      else if (fall_cyc < 0) fall_cyc = cyc;
      if (bus.WrAck) begin
        ack_cyc = cyc;
        chk("clr_wr_bus", {bus.MemWE, bus.MemAddr, bus.MemWData}, {1'b1, 15'd300, 12'hBEE});
      end else if (bus.MemWE) begin
        if (int'(bus.MemAddr) != nclr || bus.MemWData != 12'h00F) bad_clr++;
        nclr++;
      end
      tick();
      cyc++;
    end
    bus.WrReq = 1'b0;
    chk("clr_busy_cycles", busy_cnt, NPIX);
    chk("clr_write_count", nclr, NPIX);
    chk("clr_bad_writes", bad_clr, 0);
    chk("clr_fall_cycle", fall_cyc, NPIX + 1);
    chk("clr_wr_ack_cycle", ack_cyc, NPIX + 2);
    tick();
    tick();
    badw = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (i != 300 && ram[i] !== 12'h00F) badw++;
    end
    chk("clr_ram_fill", badw, 0);
    chk("clr_ram_wr", ram[300], 12'hBEE);

    // Reset in the middle of a clear
    bus.ClearReq   = 1'b1;
    bus.ClearColor = 12'hF00;
    tick();
    bus.ClearReq   = 1'b0;
    found = 0;
    for (int k = 0; k < 6000 && found == 0; k++) begin
      if (bus.MemWE && bus.MemAddr == 15'd5000) found = 1;
      else tick();
    end
    chk("mid_clr_reached", found, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", bus.ClearBusy, 0);
    chk("mid_rst_we", bus.MemWE, 0);
    tick();
    tick();
    rst = 1'b0;
    wcnt = 0;
    repeat (50) begin
      tick();
      if (bus.MemWE || bus.ClearBusy) wcnt++;
    end
    chk("post_rst_activity", wcnt, 0);
    chk("post_rst_4999", ram[4999], 12'hF00);
    chk("post_rst_5000", ram[5000], 12'h00F);
    chk("post_rst_19199", ram[19199], 12'h00F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
